// File: rtl/tdm_demux.sv
// tdm_demux: four-slot serial TDM demultiplexer with frame sync tracking.
// Define TDM_DEMUX_PARITY_EN to append an even-parity bit to every slot.
module tdm_demux #(
    parameter int SLOT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              bit_en,
    input  logic              fsync,
    output logic [SLOT_W-1:0] ch0,
    output logic [SLOT_W-1:0] ch1,
    output logic [SLOT_W-1:0] ch2,
    output logic [SLOT_W-1:0] ch3,
    output logic              frame_valid,
    output logic              sync_err,
    output logic              parity_err
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOT_BITS = SLOT_W + 1;
`else
    localparam int SLOT_BITS = SLOT_W;
`endif
    localparam int CW = $clog2(SLOT_BITS + 1);

    typedef enum logic [1:0] {
        HUNT,
        RECV,
        WAIT_SYNC
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        slot_q, slot_d;
    logic [CW-1:0]     bit_q, bit_d;
    logic [SLOT_W-1:0] sh_q [4];
    logic [SLOT_W-1:0] sh_d [4];
    logic [SLOT_W-1:0] ch_q [4];
    logic [SLOT_W-1:0] ch_d [4];
    logic              fv_q, fv_d;
    logic              se_q, se_d;

    logic              take;
    logic              last;
    logic [1:0]        cur_slot;
    logic [CW-1:0]     cur_bit;

`ifdef TDM_DEMUX_PARITY_EN
    logic              acc_q, acc_d;
    logic              ferr_q, ferr_d;
    logic              pe_q, pe_d;
    logic              bad;
`endif

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        ch_d     = ch_q;
        fv_d     = 1'b0;
        se_d     = 1'b0;
        take     = 1'b0;
        last     = 1'b0;
        cur_slot = slot_q;
        cur_bit  = bit_q;
`ifdef TDM_DEMUX_PARITY_EN
        acc_d    = acc_q;
        ferr_d   = ferr_q;
        pe_d     = 1'b0;
        bad      = ferr_q;
`endif
        if (bit_en) begin
            case (state_q)
                HUNT: begin
                    take = fsync;
                end
                RECV: begin
                    take = 1'b1;
                    se_d = fsync;
                end
                WAIT_SYNC: begin
                    take = fsync;
                    if (!fsync) begin
                        se_d    = 1'b1;
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
            // Any accepted fsync bit is slot 0 MSB; a partial frame is dropped.
            if (take && fsync) begin
                cur_slot = 2'd0;
                cur_bit  = '0;
`ifdef TDM_DEMUX_PARITY_EN
                bad      = 1'b0;
`endif
            end
        end

        if (take) begin
`ifdef TDM_DEMUX_PARITY_EN
            if (cur_bit == CW'(SLOT_W)) begin
                bad = bad | (acc_q ^ din);
            end else begin
                sh_d[cur_slot] = {sh_q[cur_slot][SLOT_W-2:0], din};
                acc_d = ((cur_bit == '0) ? 1'b0 : acc_q) ^ din;
            end
`else
            sh_d[cur_slot] = {sh_q[cur_slot][SLOT_W-2:0], din};
`endif
            last = (cur_slot == 2'd3) && (cur_bit == CW'(SLOT_BITS - 1));
            if (last) begin
                state_d = WAIT_SYNC;
                slot_d  = 2'd0;
                bit_d   = '0;
`ifdef TDM_DEMUX_PARITY_EN
                ferr_d  = 1'b0;
                if (bad) begin
                    pe_d = 1'b1;
                end else begin
                    ch_d = sh_d;
                    fv_d = 1'b1;
                end
`else
                ch_d    = sh_d;
                fv_d    = 1'b1;
`endif
            end else begin
                state_d = RECV;
`ifdef TDM_DEMUX_PARITY_EN
                ferr_d  = bad;
`endif
                if (cur_bit == CW'(SLOT_BITS - 1)) begin
                    bit_d  = '0;
                    slot_d = cur_slot + 2'd1;
                end else begin
                    bit_d  = cur_bit + CW'(1);
                    slot_d = cur_slot;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            slot_q  <= 2'd0;
            bit_q   <= '0;
            sh_q    <= '{default: '0};
            ch_q    <= '{default: '0};
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ch_q    <= ch_d;
            fv_q    <= fv_d;
            se_q    <= se_d;
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= 1'b0;
            ferr_q <= 1'b0;
            pe_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            ferr_q <= ferr_d;
            pe_q   <= pe_d;
        end
    end

    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif

    assign ch0         = ch_q[0];
    assign ch1         = ch_q[1];
    assign ch2         = ch_q[2];
    assign ch3         = ch_q[3];
    assign frame_valid = fv_q;
    assign sync_err    = se_q;

endmodule
